keypad_scanner: RTL and testbench

- Input-side counterpart of the multiplexed seven-segment display.
- Scans a 4x4 matrix keypad by driving one row low at a time and sampling the four column lines.
- Debounces each press over whole scans and emits a one-cycle key event carrying a 4-bit code.
- Shifts each accepted key into a 24-bit hex entry register, sized to feed the six-digit display directly.

---
 rtl/keypad_scanner.sv | 96 +++++++++
 tb/tb_keypad_scanner.sv | 191 +++++++++++++++++++
 2 files changed

// File: rtl/keypad_scanner.sv
// keypad_scanner: 4x4 matrix keypad scanner with whole-scan debounce and a 24-bit hex entry register.
module keypad_scanner #(
  parameter int SCAN_DIV       = 50000,
  parameter int DEBOUNCE_SCANS = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [3:0]  col_n,
  output logic [3:0]  row_n,
  input  logic        clear,
  output logic [3:0]  key,
  output logic        key_valid,
  output logic        key_held,
  output logic [23:0] val
);
  localparam int TW = SCAN_DIV < 1 ? 1 : $clog2(SCAN_DIV + 1);
  localparam logic [3:0] DS = 4'(DEBOUNCE_SCANS);
  typedef enum logic [1:0] {IDLE, DEBOUNCE, PRESSED, RELEASE} state_t;
  state_t state;
  logic [3:0] s1, s2, cand, cnt, code;
  logic [TW-1:0] timer;
  logic [1:0] row;
  logic [11:0] snap;
  logic [15:0] scan;
  logic slot_end, eval, none, single, accept, rel_done;
  assign slot_end = timer == TW'(SCAN_DIV);
  assign eval = slot_end && row == 2'd3;
  assign scan = {~s2, snap};
  assign none = scan == '0;
  assign single = !none && (scan & (scan - 16'd1)) == '0;
  always_comb begin
    code = '0;
    for (int i = 0; i < 16; i++) if (scan[i]) code = 4'(i);
  end
  assign accept = eval && single && ((state == IDLE && DS == 4'd1) ||
                  (state == DEBOUNCE && code == cand && cnt + 4'd1 == DS));
  assign rel_done = eval && none && ((state == PRESSED && DS == 4'd1) ||
                    (state == RELEASE && cnt + 4'd1 == DS));
  always_ff @(posedge clk) begin
    if (!rst) begin
      s1 <= 4'hF;
      s2 <= 4'hF;
      timer <= '0;
      row <= '0;
      row_n <= 4'b1110;
      snap <= '0;
      state <= IDLE;
      cnt <= '0;
      cand <= '0;
      key <= '0;
      key_valid <= 1'b0;
      key_held <= 1'b0;
      val <= '0;
    end else begin
      s1 <= col_n;
      s2 <= s1;
      timer <= slot_end ? '0 : timer + 1'b1;
      key_valid <= accept;
      key <= accept ? code : key;
      key_held <= accept ? 1'b1 : rel_done ? 1'b0 : key_held;
      val <= clear ? '0 : accept ? {val[19:0], code} : val;
      // rows 0..2 shift down into snap[3:0], [7:4], [11:8]; the row-3 shift-in is overwritten next scan
      if (slot_end) begin
        row <= row + 2'd1;
        row_n <= {row_n[2:0], row_n[3]};
        snap <= {~s2, snap[11:4]};
      end
      if (eval) begin
        case (state)
          IDLE: if (single) begin
            cand <= code;
            cnt <= 4'd1;
            state <= accept ? PRESSED : DEBOUNCE;
          end
          DEBOUNCE: if (!single) state <= IDLE;
            else if (code != cand) begin
              cand <= code;
              cnt <= 4'd1;
            end else begin
              cnt <= cnt + 4'd1;
              state <= accept ? PRESSED : DEBOUNCE;
            end
          PRESSED: if (none) begin
            cnt <= 4'd1;
            state <= rel_done ? IDLE : RELEASE;
          end
          RELEASE: if (!none) state <= PRESSED;
            else begin
              cnt <= cnt + 4'd1;
              state <= rel_done ? IDLE : RELEASE;
            end
        endcase
      end
    end
  end
endmodule

// File: tb/tb_keypad_scanner.sv
// tb_keypad_scanner: scan-level keypad model driving the scanner, checked against a run-counting reference model.
module tb_keypad_scanner;
  localparam int DS = 2;
  logic clk = 0, rst = 0, clear = 0;
  logic [3:0] col_n, row_n, key;
  logic key_valid, key_held;
  logic [23:0] val;
  logic [15:0] keys = '0;
  int total = 0, bad = 0;
  bit m_pressed;
  int m_run, m_rel, m_pulse, obs_pulses;
  logic [3:0] m_cand, m_key, obs_key;
  logic [23:0] m_val;

  keypad_scanner #(.SCAN_DIV(3), .DEBOUNCE_SCANS(DS)) dut (
    .clk(clk), .rst(rst), .col_n(col_n), .row_n(row_n), .clear(clear),
    .key(key), .key_valid(key_valid), .key_held(key_held), .val(val));

  always #5 clk = ~clk;

  // a pressed key connects its row line to its column line
  always_comb begin
    col_n = 4'hF;
    for (int r = 0; r < 4; r++)
      for (int c = 0; c < 4; c++)
        if (row_n[r] === 1'b0 && keys[4*r+c]) col_n[c] = 1'b0;
  end

  task model_reset;
    m_pressed = 0; m_run = 0; m_rel = 0; m_pulse = 0;
    m_cand = '0; m_key = '0; m_val = '0;
  endtask

  // one full 16-clock scan with key set k; clr=1 clears on the evaluation edge, clr=2 mid-scan
  task do_scan(input logic [15:0] k, input int clr);
    int n;
    logic [3:0] c;
    keys = k;
    obs_pulses = 0;
    obs_key = '0;
    for (int i = 1; i <= 16; i++) begin
      if ((clr == 1 && i == 16) || (clr == 2 && i == 8)) clear = 1;
      @(posedge clk); #1;
      clear = 0;
      if (key_valid) begin obs_pulses++; obs_key = key; end
    end
    m_pulse = 0;
    if (clr == 2) m_val = '0;
    n = $countones(k);
    c = '0;
    for (int j = 0; j < 16; j++) if (k[j]) c = 4'(j);
    if (!m_pressed) begin
      if (n == 1) begin
        m_run = (m_run > 0 && c == m_cand) ? m_run + 1 : 1;
        m_cand = c;
        if (m_run >= DS) begin
          m_pressed = 1; m_rel = 0; m_key = c; m_pulse = 1;
          m_val = {m_val[19:0], c};
        end
      end else m_run = 0;
    end else if (k == 0) begin
      m_rel++;
      if (m_rel >= DS) begin m_pressed = 0; m_run = 0; end
    end else m_rel = 0;
    if (clr == 1) m_val = '0;
  endtask

  task test_reset;
    keys = '0; rst = 0; clear = 0;
    repeat (2) @(posedge clk);
    #1;
    total++; if (row_n !== 4'b1110) begin bad++; $display("FAIL reset row_n got=%b exp=1110", row_n); end
    total++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin bad++; $display("FAIL reset flags got=%b%b exp=00", key_valid, key_held); end
    total++; if (val !== 24'h0 || key !== 4'h0) begin bad++; $display("FAIL reset val/key got=%h/%h exp=0/0", val, key); end
    rst = 1;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    total++; if (row_n !== 4'b1110) begin bad++; $display("FAIL row_hold got=%b exp=1110", row_n); end
    @(posedge clk); #1;
    total++; if (row_n !== 4'b1101) begin bad++; $display("FAIL row_step got=%b exp=1101", row_n); end
    repeat (12) @(posedge clk);
    #1;
  endtask

  task test_clean;
    logic [15:0] p [5] = '{16'h0040, 16'h0040, 16'h0040, 16'h0000, 16'h0000};
    foreach (p[i]) begin
      do_scan(p[i], 0);
      total++; if (obs_pulses !== m_pulse) begin bad++; $display("FAIL clean pulses scan%0d got=%0d exp=%0d", i, obs_pulses, m_pulse); end
      if (m_pulse == 1) begin total++; if (obs_key !== m_key) begin bad++; $display("FAIL clean key got=%h exp=%h", obs_key, m_key); end end
      total++; if (key_held !== m_pressed) begin bad++; $display("FAIL clean held scan%0d got=%b exp=%b", i, key_held, m_pressed); end
      total++; if (val !== m_val) begin bad++; $display("FAIL clean val got=%h exp=%h", val, m_val); end
    end
    total++; if (key !== 4'h6 || val !== 24'h000006) begin bad++; $display("FAIL clean final key/val got=%h/%h exp=6/000006", key, val); end
  endtask

  task test_bounce;
    logic [15:0] p [10] = '{16'h0040, 16'h0000, 16'h0000, 16'h0040, 16'h0040,
                            16'h0000, 16'h0040, 16'h0040, 16'h0000, 16'h0000};
    foreach (p[i]) begin
      do_scan(p[i], 0);
      total++; if (obs_pulses !== m_pulse) begin bad++; $display("FAIL bounce pulses scan%0d got=%0d exp=%0d", i, obs_pulses, m_pulse); end
      if (m_pulse == 1) begin total++; if (obs_key !== m_key) begin bad++; $display("FAIL bounce key got=%h exp=%h", obs_key, m_key); end end
      total++; if (key_held !== m_pressed) begin bad++; $display("FAIL bounce held scan%0d got=%b exp=%b", i, key_held, m_pressed); end
      total++; if (val !== m_val) begin bad++; $display("FAIL bounce val got=%h exp=%h", val, m_val); end
    end
  endtask

  task test_ghost;
    logic [15:0] p [7] = '{16'h0022, 16'h0022, 16'h0022, 16'h0020, 16'h0020, 16'h0000, 16'h0000};
    foreach (p[i]) begin
      do_scan(p[i], 0);
      total++; if (obs_pulses !== m_pulse) begin bad++; $display("FAIL ghost pulses scan%0d got=%0d exp=%0d", i, obs_pulses, m_pulse); end
      if (m_pulse == 1) begin total++; if (obs_key !== m_key) begin bad++; $display("FAIL ghost key got=%h exp=%h", obs_key, m_key); end end
      total++; if (key_held !== m_pressed) begin bad++; $display("FAIL ghost held scan%0d got=%b exp=%b", i, key_held, m_pressed); end
    end
    total++; if (key !== 4'h5) begin bad++; $display("FAIL ghost final key got=%h exp=5", key); end
  endtask

  task test_entry;
    logic [15:0] k;
    for (int d = 1; d <= 11; d++) begin
      k = (d <= 7) ? 16'(1) << d : (d == 8 || d == 9) ? 16'h0100 : 16'h0000;
      do_scan(d == 7 ? k : k, (d == 9) ? 1 : 0);
      if (d <= 7) do_scan(k, 0);
      total++; if (obs_pulses !== m_pulse) begin bad++; $display("FAIL entry pulses d%0d got=%0d exp=%0d", d, obs_pulses, m_pulse); end
      if (m_pulse == 1) begin total++; if (obs_key !== m_key) begin bad++; $display("FAIL entry key got=%h exp=%h", obs_key, m_key); end end
      total++; if (val !== m_val) begin bad++; $display("FAIL entry val d%0d got=%h exp=%h", d, val, m_val); end
      if (d <= 7) begin do_scan('0, 0); do_scan('0, 0); end
      if (d == 7) begin
        total++; if (val !== 24'h234567) begin bad++; $display("FAIL entry digits got=%h exp=234567", val); end
        do_scan('0, 2);
        total++; if (val !== 24'h0) begin bad++; $display("FAIL entry clear got=%h exp=0", val); end
      end
    end
    total++; if (val !== 24'h0 || key !== 4'h8) begin bad++; $display("FAIL entry clear_accept got=%h/%h exp=0/8", val, key); end
  endtask

  task test_reset_mid;
    do_scan(16'h0040, 0);
    do_scan(16'h0040, 0);
    total++; if (key_held !== 1'b1) begin bad++; $display("FAIL mid pre held got=%b exp=1", key_held); end
    repeat (5) @(posedge clk);
    #1 rst = 0;
    @(posedge clk); #1;
    rst = 1;
    model_reset();
    total++; if (row_n !== 4'b1110 || key !== 4'h0 || val !== 24'h0) begin bad++; $display("FAIL mid reset row/key/val got=%b/%h/%h exp=1110/0/0", row_n, key, val); end
    total++; if (key_valid !== 1'b0 || key_held !== 1'b0) begin bad++; $display("FAIL mid reset flags got=%b%b exp=00", key_valid, key_held); end
    for (int i = 0; i < 2; i++) begin
      do_scan(16'h0040, 0);
      total++; if (obs_pulses !== m_pulse) begin bad++; $display("FAIL mid pulses scan%0d got=%0d exp=%0d", i, obs_pulses, m_pulse); end
      if (m_pulse == 1) begin total++; if (obs_key !== 4'h6) begin bad++; $display("FAIL mid key got=%h exp=6", obs_key); end end
      total++; if (key_held !== m_pressed) begin bad++; $display("FAIL mid held got=%b exp=%b", key_held, m_pressed); end
    end
    do_scan('0, 0);
    do_scan('0, 0);
  endtask

  task test_random;
    logic [15:0] k = '0;
    int clr;
    for (int i = 0; i < 60; i++) begin
      case ($urandom_range(0, 3))
        0: k = '0;
        1: k = k;
        2: k = 16'(1) << $urandom_range(0, 15);
        default: k = (16'(1) << $urandom_range(0, 15)) | (16'(1) << $urandom_range(0, 15));
      endcase
      clr = ($urandom_range(0, 9) == 0) ? int'($urandom_range(1, 2)) : 0;
      do_scan(k, clr);
      total++; if (obs_pulses !== m_pulse) begin bad++; $display("FAIL rand pulses scan%0d got=%0d exp=%0d", i, obs_pulses, m_pulse); end
      if (m_pulse == 1) begin total++; if (obs_key !== m_key) begin bad++; $display("FAIL rand key got=%h exp=%h", obs_key, m_key); end end
      total++; if (key_held !== m_pressed) begin bad++; $display("FAIL rand held scan%0d got=%b exp=%b", i, key_held, m_pressed); end
      total++; if (val !== m_val) begin bad++; $display("FAIL rand val scan%0d got=%h exp=%h", i, val, m_val); end
    end
  endtask

  initial begin
    test_reset();
    test_clean();
    test_bounce();
    test_ghost();
    test_entry();
    test_reset_mid();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
